// File: rtl/tff_toggle_pkg.sv
// Shared types and default timing constants for the push-button toggle generator.
package tff_toggle_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } tff_state_t;

    localparam int STABLE_CYCLES_DEF = 4;
    localparam int HOLD_CYCLES_DEF   = 8;
    localparam int REPEAT_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/tff_toggle_gen.sv
// Debounces a raw push-button into single-cycle toggle pulses with optional
// hold-to-repeat, and keeps a wrapping count of the pulses emitted.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | button released and stable
// DEB_PRESS   | button seen high, waiting for STABLE_CYCLES of high
// PRESSED     | press accepted, timing the hold before auto-repeat
// REPEAT      | auto-repeat active, pulse every REPEAT_CYCLES
// DEB_RELEASE | button seen low, waiting for STABLE_CYCLES of low
module tff_toggle_gen
    import tff_toggle_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       enable,
    output logic       t_pulse,
    output logic       btn_level,
    output logic [7:0] pulse_count,
    output logic       busy
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam bit               HOLD_EN     = (HOLD_CYCLES != 0);

    logic             btn_sync;
    tff_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // cnt free-runs and is cleared on every transition; each branch that
    // changes state overrides the default increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            t_pulse     <= 1'b0;
            btn_level   <= 1'b0;
            pulse_count <= 8'd0;
            busy        <= 1'b0;
        end else begin
            t_pulse <= 1'b0;
            cnt     <= cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= DEB_PRESS;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        t_pulse   <= enable;
                        if (enable) pulse_count <= pulse_count + 8'd1;
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state <= DEB_RELEASE;
                        cnt   <= '0;
                    end else if (HOLD_EN && (cnt == HOLD_LAST)) begin
                        state   <= REPEAT;
                        cnt     <= '0;
                        t_pulse <= enable;
                        if (enable) pulse_count <= pulse_count + 8'd1;
                    end
                end
                REPEAT: begin
                    if (!btn_sync) begin
                        state <= DEB_RELEASE;
                        cnt   <= '0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt     <= '0;
                        t_pulse <= enable;
                        if (enable) pulse_count <= pulse_count + 8'd1;
                    end
                end
                DEB_RELEASE: begin
                    if (btn_sync) begin
                        // Bounce back to pressed: hold timing starts over.
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_toggle_gen.sv
// Scoreboard bench: stimulus pushes expected pulse/level events computed from
// the press/release latency rules; a negedge monitor pops and compares them.
module tb_tff_toggle_gen;

    localparam int S = 4;
    localparam int H = 8;
    localparam int R = 4;

    typedef struct {
        int         e;
        logic [7:0] c;
    } pulse_t;

    typedef struct {
        int   e;
        logic v;
    } level_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_in = 1'b0;
    logic       enable = 1'b1;
    logic       t_pulse;
    logic       btn_level;
    logic [7:0] pulse_count;
    logic       busy;

    int         edge_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_count = 8'd0;
    logic       qt;
    logic       prev_level = 1'b0;
    logic       prev_pulse = 1'b0;

    pulse_t pq[$];
    level_t lq[$];

    tff_toggle_gen #(
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .REPEAT_CYCLES (R),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .enable      (enable),
        .t_pulse     (t_pulse),
        .btn_level   (btn_level),
        .pulse_count (pulse_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Downstream Tff fed by t_pulse, reset together with the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) qt <= 1'b0;
        else if (t_pulse) qt <= ~qt;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push_pulse(input int e, input logic en);
        pulse_t p;
        if (en) begin
            exp_count = exp_count + 8'd1;
            p.e = e;
            p.c = exp_count;
            pq.push_back(p);
        end
    endtask

    task automatic push_level(input int e, input logic v);
        level_t l;
        l.e = e;
        l.v = v;
        lq.push_back(l);
    endtask

    // Reference model for one clean press: first high sample at edge k,
    // L consecutive high samples, followed by a long low period.
    task automatic model_press(input int k, input int len, input logic en);
        int e;
        if (len >= S + 1) begin
            push_level(k + 2 + S, 1'b1);
            push_pulse(k + 2 + S, en);
            if (H != 0) begin
                e = k + 2 + S + H;
                while (e <= k + len + 1) begin
                    push_pulse(e, en);
                    e += R;
                end
            end
            push_level(k + len + 2 + S, 1'b0);
        end
    endtask

    task automatic drive_press(input int len, input int gap, input logic en);
        int k;
        @(negedge clk);
        enable = en;
        btn_in = 1'b1;
        k = edge_cnt + 1;
        model_press(k, len, en);
        repeat (len) @(negedge clk);
        btn_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (pq.size() != 0 || lq.size() != 0); i++) @(negedge clk);
        chk("drain_pulse_queue", pq.size(), 0);
        chk("drain_level_queue", lq.size(), 0);
        pq.delete();
        lq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_in = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("reset_t_pulse", t_pulse, 0);
        chk("reset_btn_level", btn_level, 0);
        chk("reset_pulse_count", pulse_count, 0);
        chk("reset_busy", busy, 0);
        exp_count = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_level = 1'b0;
            prev_pulse = 1'b0;
        end else begin
            if (prev_pulse) chk("tff_qt_vs_count", qt, pulse_count[0]);
            if (t_pulse) begin
                if (pq.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    pulse_t p;
                    p = pq.pop_front();
                    chk("pulse_edge", edge_cnt, p.e);
                    chk("pulse_count_at_pulse", pulse_count, p.c);
                end
            end
            if (btn_level != prev_level) begin
                if (lq.size() == 0) begin
                    chk("unexpected_level_change", 1, 0);
                end else begin
                    level_t l;
                    l = lq.pop_front();
                    chk("level_edge", edge_cnt, l.e);
                    chk("level_value", btn_level, l.v);
                end
            end
            prev_level = btn_level;
            prev_pulse = t_pulse;
        end
    end

    initial begin
        int k;
        int n;

        // Reset state before any clock edge has been seen by the DUT.
        #1;
        chk("init_t_pulse", t_pulse, 0);
        chk("init_btn_level", btn_level, 0);
        chk("init_pulse_count", pulse_count, 0);
        chk("init_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single clean press of 6 samples
        drive_press(6, S + 4, 1'b1);
        drain();
        chk("t1_pulse_count", pulse_count, 1);
        chk("t1_btn_level", btn_level, 0);
        chk("t1_busy", busy, 0);

        // 2: glitches shorter than the debounce window
        drive_press(3, S + 4, 1'b1);
        drive_press(2, S + 4, 1'b1);
        drain();
        chk("t2_pulse_count", pulse_count, 1);
        chk("t2_btn_level", btn_level, 0);
        chk("t2_busy", busy, 0);

        // 3: bouncy release 0,1,0,1 then low
        @(negedge clk);
        enable = 1'b1;
        btn_in = 1'b1;
        k = edge_cnt + 1;
        push_level(k + 2 + S, 1'b1);
        push_pulse(k + 2 + S, 1'b1);
        repeat (10) @(negedge clk);
        btn_in = 1'b0;
        @(negedge clk) btn_in = 1'b1;
        @(negedge clk) btn_in = 1'b0;
        @(negedge clk) btn_in = 1'b1;
        @(negedge clk) btn_in = 1'b0;
        push_level(edge_cnt + 1 + 2 + S, 1'b0);
        repeat (S + 6) @(negedge clk);
        drain();
        chk("t3_pulse_count", pulse_count, 2);
        chk("t3_busy", busy, 0);

        // 4: long hold with auto-repeat
        drive_press(40, S + 4, 1'b1);
        drain();
        chk("t4_pulse_count", pulse_count, exp_count);
        chk("t4_tff", qt, pulse_count[0]);

        // 5: masked press then enabled press
        drain();
        do_reset();
        drive_press(6, S + 4, 1'b0);
        drain();
        chk("t5_masked_count", pulse_count, 0);
        drive_press(6, S + 4, 1'b1);
        drain();
        chk("t5_enabled_count", pulse_count, 1);

        // 6: reset while in REPEAT, button still held afterwards
        @(negedge clk);
        enable = 1'b1;
        btn_in = 1'b1;
        k = edge_cnt + 1;
        push_level(k + 2 + S, 1'b1);
        push_pulse(k + 2 + S, 1'b1);
        push_pulse(k + 2 + S + H, 1'b1);
        push_pulse(k + 2 + S + H + R, 1'b1);
        while (edge_cnt < k + 2 + S + H + R + 2) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        chk("t6_level_before", btn_level, 1);
        chk("t6_queue_before", pq.size(), 0);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_t_pulse", t_pulse, 0);
        chk("t6_async_btn_level", btn_level, 0);
        chk("t6_async_pulse_count", pulse_count, 0);
        chk("t6_async_busy", busy, 0);
        pq.delete();
        lq.delete();
        exp_count = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = edge_cnt;
        model_press(n + 1, 6, 1'b1);
        repeat (6) @(negedge clk);
        btn_in = 1'b0;
        repeat (S + 6) @(negedge clk);
        drain();
        chk("t6_count_after", pulse_count, 1);

        // Random presses, lengths and enables against the model
        for (int i = 0; i < 40; i++) begin
            drive_press(int'($urandom_range(1, 30)), int'($urandom_range(S + 3, S + 8)),
                        logic'($urandom_range(0, 3) != 0));
        end
        drain();
        chk("rand_pulse_count", pulse_count, exp_count);
        chk("rand_tff", qt, pulse_count[0]);

        // 7: 256 accepted presses wrap the count back to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive_press(6, S + 3, 1'b1);
            if (i == 127) chk("t7_half_count", pulse_count, 128);
        end
        drain();
        chk("t7_wrap_count", pulse_count, 0);
        chk("t7_tff", qt, pulse_count[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tff_toggle_gen.md
Name: tff_toggle_gen

Overview:
- Upstream stage of the Tff stage. Converts a raw, bouncing, asynchronous push-button into clean single-cycle toggle pulses for the Tff `t` input.
- Processing chain: 2-flop synchronizer, press/release debounce FSM, optional hold-to-auto-repeat.
- Keeps a wrapping count of the pulses it emits, so the bench can predict the downstream Tff state.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized cycles required to accept a press or a release. Legal range is 1 to 2^CNT_W.
- HOLD_CYCLES, 8: cycles held in PRESSED before auto-repeat starts. 0 disables repeat.
- REPEAT_CYCLES, 4: period between auto-repeat pulses. Legal range is 1 to 2^CNT_W.
- CNT_W, 16: width of the internal shared cycle counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- btn_in  in  1  raw asynchronous button level, active high
- enable  in  1  when 0, t_pulse is masked. The FSM keeps tracking.
- t_pulse  out  1  one-cycle toggle request, drives the Tff `t` input
- btn_level  out  1  debounced button level
- pulse_count  out  8  number of asserted t_pulse cycles, modulo 256
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: reset=0 asynchronously clears all outputs to 0.
  - Synchronizer flops = 0, cnt = 0, state = IDLE.
  - On release, operation starts at the next clk edge.
  - A button still held across reset is re-debounced and produces one new pulse.
- Synchronizer: btn_in is sampled into s1; s1 moves into btn_sync. Nothing else samples btn_in.
- cnt is a shared counter. It is cleared on every state transition and increments on every other cycle.
- All outputs are registered.
- FSM states: IDLE, DEB_PRESS, PRESSED, REPEAT, DEB_RELEASE.
  - IDLE: btn_sync=1 -> DEB_PRESS.
  - DEB_PRESS:
    - btn_sync=0 -> IDLE (glitch rejected, no pulse).
    - btn_sync=1 and cnt==STABLE_CYCLES-1 -> PRESSED, btn_level<=1, emit pulse.
  - PRESSED:
    - btn_sync=0 -> DEB_RELEASE.
    - Otherwise, if HOLD_CYCLES!=0 and cnt==HOLD_CYCLES-1 -> REPEAT, emit pulse.
  - REPEAT:
    - btn_sync=0 -> DEB_RELEASE.
    - Otherwise, at cnt==REPEAT_CYCLES-1, emit pulse and clear cnt (stay in REPEAT).
  - DEB_RELEASE:
    - btn_sync=1 -> PRESSED (bounce, no pulse, hold timing restarts).
    - btn_sync=0 and cnt==STABLE_CYCLES-1 -> IDLE, btn_level<=0.
- Emit pulse: t_pulse<=enable for exactly one cycle. If enable=1, pulse_count<=pulse_count+1, wrapping 255->0.
  - A pulse masked by enable=0 is lost. It is not deferred and not counted.
- Press latency: btn_in is first sampled high at edge k and stays stable. Then:
  - DEB_PRESS is entered at edge k+2.
  - t_pulse and btn_level rise at edge k+2+STABLE_CYCLES.
  - t_pulse falls at the next edge.
- Release latency: btn_level falls at edge j+2+STABLE_CYCLES, where j is the first edge btn_in is sampled low.
- Simultaneous events:
  - The release check (btn_sync=0) takes priority over a hold or repeat expiry in the same cycle. No pulse is emitted in that case.
  - enable changing in the cycle of a pulse takes effect immediately, because it is sampled at the pulse edge.
- Consistency invariant: a Tff whose t input is driven by t_pulse, reset together with this block, satisfies qt == pulse_count[0] at all times.

Decomposition:
- Package tff_toggle_pkg holds:
  - the state enum, with explicit 3-bit encoding IDLE=0, DEB_PRESS=1, PRESSED=2, REPEAT=3, DEB_RELEASE=4;
  - default constants for STABLE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES.
- One sub-module: sync_2ff (1-bit, async active-low reset to 0), reusable across the codebase.
- The FSM, counters and output registers stay in tff_toggle_gen.

Test Plan:
All scenarios use defaults STABLE=4, HOLD=8, REPEAT=4 and enable=1 unless stated.
1. Reset, then btn_in=1 sampled first at edge 10 and held 6 cycles, then 0. Require:
   - t_pulse high only in the cycle after edge 16;
   - btn_level=1 from edge 16;
   - pulse_count=1;
   - btn_level back to 0 after the release debounce.
2. Glitches: btn_in high for 3 cycles, low, then high for 2 cycles. Require t_pulse never asserted, btn_level stays 0, pulse_count=0, and busy returns to 0.
3. Bouncy release: after an accepted press, btn_in goes 0,1,0,1 at one-cycle intervals, then stays low. Require no extra pulse and btn_level falling exactly STABLE+2 edges after the final low sample.
4. Auto-repeat: hold btn_in for 40 cycles. Require:
   - first pulse at edge k+6;
   - second pulse 8 edges later;
   - further pulses every 4 edges until release;
   - pulse_count equal to the number of pulses seen;
   - a Tff driven by t_pulse satisfying qt==pulse_count[0].
5. enable=0 during the first accepted press, then enable=1 for a second press. Require:
   - no t_pulse and pulse_count=0 after the first press, with btn_level still toggling;
   - exactly one pulse and pulse_count=1 after the second press.
6. Reset mid-operation: assert reset while in REPEAT. Require all outputs 0 immediately, without waiting for clk. After release with btn_in still high, require exactly one new pulse at edge k+6.
7. Wrap: 256 accepted presses. Require pulse_count to wrap back to 0.
